// File: rtl/i2c_pkg.sv
// Shared I2C definitions: SCL generator state encoding and the system-wide
// default quarter-period divider.
package i2c_pkg;

  // Quarter-period (ref_clk cycles) used after reset until the first load.
  localparam int DEFAULT_QDIV = 10;

  // SCL generator states: idle plus the four quarter-period phases.
  // PH0/PH1 hold SCL low, PH2/PH3 hold SCL high.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH0  = 3'd1,
    ST_PH1  = 3'd2,
    ST_PH2  = 3'd3,
    ST_PH3  = 3'd4
  } state_t;

endpackage

// File: rtl/i2c_clk_gen.sv
// I2C master SCL generator with a runtime-programmable quarter-period divider,
// per-phase strobes for the bit engine and slave clock-stretch support.
// Every output comes straight from a register.
module i2c_clk_gen #(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_QDIV = i2c_pkg::DEFAULT_QDIV
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] qdiv,
  input  logic             scl_i,
  output logic             scl_o,
  output logic             busy,
  output logic             data_tick,
  output logic             sample_tick,
  output logic             fall_tick,
  output logic             stretching
);

  import i2c_pkg::*;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] q_lat, q_lat_n;
  logic             scl_n, busy_n;
  logic             data_n, sample_n, fall_n, stretch_n;

  logic [WIDTH-1:0] qdiv_eff;
  logic             phase_end;

  // A programmed divider of 0 is treated as 1 so a phase is never empty.
  assign qdiv_eff  = (qdiv == '0) ? WIDTH'(1) : qdiv;
  // q_lat is always >= 1, so q_lat-1 never wraps and cnt never exceeds it.
  assign phase_end = (cnt == (q_lat - WIDTH'(1)));

  // Next-state, counter and registered-output decode.
  // NOTE: every signal written here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    q_lat_n   = q_lat;
    scl_n     = scl_o;
    busy_n    = busy;
    data_n    = 1'b0;
    sample_n  = 1'b0;
    fall_n    = 1'b0;
    stretch_n = 1'b0;

    unique case (state)
      ST_IDLE: begin
        scl_n  = 1'b1;
        busy_n = 1'b0;
        cnt_n  = '0;
        if (en) begin
          // Start edge: latch the divider and pull SCL low, no fall_tick.
          q_lat_n = qdiv_eff;
          state_n = ST_PH0;
          scl_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end

      ST_PH0: begin
        if (phase_end) begin
          cnt_n   = '0;
          state_n = ST_PH1;
          data_n  = 1'b1;   // mid-low: SDA may change
        end else begin
          cnt_n = cnt + WIDTH'(1);
        end
      end

      ST_PH1: begin
        if (phase_end) begin
          cnt_n   = '0;
          state_n = ST_PH2;
          scl_n   = 1'b1;   // release SCL
        end else begin
          cnt_n = cnt + WIDTH'(1);
        end
      end

      ST_PH2: begin
        if (!scl_i) begin
          // Slave is holding SCL low: freeze the high phase until it lets go.
          cnt_n     = '0;
          stretch_n = 1'b1;
        end else if (phase_end) begin
          cnt_n    = '0;
          state_n  = ST_PH3;
          sample_n = 1'b1;  // mid-high: SDA is valid
        end else begin
          cnt_n = cnt + WIDTH'(1);
        end
      end

      ST_PH3: begin
        if (phase_end) begin
          cnt_n = '0;
          if (en) begin
            // Period boundary: the only place the divider is reloaded.
            state_n = ST_PH0;
            scl_n   = 1'b0;
            fall_n  = 1'b1;
            q_lat_n = qdiv_eff;
          end else begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + WIDTH'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        scl_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, counter, divider latch and output registers; reset wins over all.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      q_lat       <= WIDTH'(DEFAULT_QDIV);
      scl_o       <= 1'b1;
      busy        <= 1'b0;
      data_tick   <= 1'b0;
      sample_tick <= 1'b0;
      fall_tick   <= 1'b0;
      stretching  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      q_lat       <= q_lat_n;
      scl_o       <= scl_n;
      busy        <= busy_n;
      data_tick   <= data_n;
      sample_tick <= sample_n;
      fall_tick   <= fall_n;
      stretching  <= stretch_n;
    end
  end

endmodule

// File: tb/tb_i2c_clk_gen.sv
// Directed self-checking bench for i2c_clk_gen.
module tb_i2c_clk_gen;

  localparam int WIDTH = 16;

  logic             ref_clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] qdiv;
  logic             scl_i;
  logic             scl_o;
  logic             busy;
  logic             data_tick;
  logic             sample_tick;
  logic             fall_tick;
  logic             stretching;

  int checks = 0;
  int errors = 0;

  always #5 ref_clk = ~ref_clk;

  i2c_clk_gen #(.WIDTH(WIDTH), .DEFAULT_QDIV(10)) dut (
    .ref_clk     (ref_clk),
    .rst_n       (rst_n),
    .en          (en),
    .qdiv        (qdiv),
    .scl_i       (scl_i),
    .scl_o       (scl_o),
    .busy        (busy),
    .data_tick   (data_tick),
    .sample_tick (sample_tick),
    .fall_tick   (fall_tick),
    .stretching  (stretching)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " scl_o"},       scl_o,       1'b1);
    check({tag, " busy"},        busy,        1'b0);
    check({tag, " data_tick"},   data_tick,   1'b0);
    check({tag, " sample_tick"}, sample_tick, 1'b0);
    check({tag, " fall_tick"},   fall_tick,   1'b0);
    check({tag, " stretching"},  stretching,  1'b0);
  endtask

  // Step through period positions k_from..k_to of an unstretched period with
  // quarter q, where position 0 is the edge that pulled SCL low.
  task automatic run_cycles(input int q, input int k_from, input int k_to,
                            input string tag);
    for (int k = k_from; k <= k_to; k++) begin
      int p;
      string t;
      p = k % (4 * q);
      t = $sformatf("%s k%0d", tag, k);
      step();
      check({t, " scl_o"},       scl_o,       p >= 2 * q);
      check({t, " data_tick"},   data_tick,   p == q);
      check({t, " sample_tick"}, sample_tick, p == 3 * q);
      check({t, " fall_tick"},   fall_tick,   p == 0);
      check({t, " busy"},        busy,        1'b1);
      check({t, " stretching"},  stretching,  1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with en high: outputs idle.
    rst_n = 1'b0;
    en    = 1'b1;
    qdiv  = WIDTH'(3);
    scl_i = 1'b1;
    repeat (3) step();
    check_idle("reset");

    // Release: the start edge pulls SCL low one cycle later, no fall_tick.
    rst_n = 1'b1;
    step();
    check("start scl_o",     scl_o,     1'b0);
    check("start busy",      busy,      1'b1);
    check("start fall_tick", fall_tick, 1'b0);
    check("start data_tick", data_tick, 1'b0);

    // Steady run Q=3: two full 12-cycle periods.
    run_cycles(3, 1, 24, "q3");

    // qdiv=0 applied mid-period: current period stays Q=3, then Q=1.
    qdiv = '0;
    run_cycles(3, 1, 12, "q3_reload");
    run_cycles(1, 1, 8, "q0");

    // Load Q=4 at the next boundary.
    qdiv = WIDTH'(4);
    run_cycles(1, 1, 4, "q1_last");

    // Divider change 4->2 in PH1: this period stays 16, next is 8.
    run_cycles(4, 1, 5, "q4");
    qdiv = WIDTH'(2);
    run_cycles(4, 6, 16, "q4_hold");
    run_cycles(2, 1, 8, "q2");

    // Back to Q=4 for the stretch test.
    run_cycles(2, 1, 3, "q2_last");
    qdiv = WIDTH'(4);
    run_cycles(2, 4, 8, "q2_last");

    // Stretch: slave holds SCL low for 10 cycles right after it is released.
    run_cycles(4, 1, 8, "pre_stretch");
    scl_i = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("stretch c%0d stretching", i),  stretching,  1'b1);
      check($sformatf("stretch c%0d scl_o", i),       scl_o,       1'b1);
      check($sformatf("stretch c%0d sample_tick", i), sample_tick, 1'b0);
      check($sformatf("stretch c%0d busy", i),        busy,        1'b1);
    end
    scl_i = 1'b1;
    run_cycles(4, 9, 16, "post_stretch");
    run_cycles(4, 1, 16, "after_stretch");

    // en dropped in PH1: period completes, no fall_tick, busy falls at end.
    run_cycles(4, 1, 5, "drop");
    en = 1'b0;
    run_cycles(4, 6, 15, "drop_finish");
    step();
    check_idle("drop_end");
    repeat (3) step();
    check_idle("drop_idle");

    // Restart, then reset in PH2: idle next cycle, no sample_tick afterwards.
    en = 1'b1;
    step();
    check("restart scl_o", scl_o, 1'b0);
    check("restart busy",  busy,  1'b1);
    run_cycles(4, 1, 10, "pre_rst");
    rst_n = 1'b0;
    en    = 1'b0;
    step();
    check_idle("rst_ph2");
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_idle($sformatf("rst_ph2_after c%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
